// File: rtl/midi_msg_ctrl.sv
// MIDI byte-stream sequencer: assembles Note On/Off events with running status and
// channel filtering, presents them on a one-entry valid/ready port and drives the LED.
module midi_msg_ctrl #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter logic       OMNI    = 1'b0
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    input  logic       frame_err_i,
    input  logic       evt_ready_i,
    output logic       evt_valid_o,
    output logic       evt_on_o,
    output logic [3:0] evt_chan_o,
    output logic [6:0] evt_note_o,
    output logic [6:0] evt_vel_o,
    output logic       overrun_o,
    output logic [7:0] led_o
);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SKIP} state_t;

    state_t     state_q, state_d;
    logic       runOn_q, runOn_d;
    logic [3:0] runChan_q, runChan_d;
    logic       runDiscard_q, runDiscard_d;
    logic [1:0] skipLen_q, skipLen_d;
    logic [1:0] skipCnt_q, skipCnt_d;
    logic [6:0] note_q, note_d;
    logic       evtValid_q, evtValid_d;
    logic       evtOn_q, evtOn_d;
    logic [3:0] evtChan_q, evtChan_d;
    logic [6:0] evtNote_q, evtNote_d;
    logic [6:0] evtVel_q, evtVel_d;
    logic       overrun_q, overrun_d;
    logic [7:0] led_q, led_d;

    logic complete;
    logic isOn;
    logic isRealtime;

    assign isRealtime = (byte_data_i[7:3] == 5'b11111);
    assign isOn       = runOn_q && (byte_data_i[6:0] != 7'd0);

    always_comb begin
        state_d      = state_q;
        runOn_d      = runOn_q;
        runChan_d    = runChan_q;
        runDiscard_d = runDiscard_q;
        skipLen_d    = skipLen_q;
        skipCnt_d    = skipCnt_q;
        note_d       = note_q;
        evtValid_d   = evtValid_q;
        evtOn_d      = evtOn_q;
        evtChan_d    = evtChan_q;
        evtNote_d    = evtNote_q;
        evtVel_d     = evtVel_q;
        overrun_d    = overrun_q;
        led_d        = led_q;
        complete     = 1'b0;

        if (frame_err_i) begin
            state_d      = IDLE;
            runOn_d      = 1'b0;
            runChan_d    = 4'd0;
            runDiscard_d = 1'b0;
            skipLen_d    = 2'd0;
        end else if (byte_valid_i && !isRealtime) begin
            if (byte_data_i[7]) begin
                runOn_d      = 1'b0;
                runChan_d    = 4'd0;
                runDiscard_d = 1'b0;
                skipLen_d    = 2'd0;
                case (byte_data_i[7:4])
                    4'h8, 4'h9: begin
                        runOn_d      = byte_data_i[4];
                        runChan_d    = byte_data_i[3:0];
                        runDiscard_d = !(OMNI || (byte_data_i[3:0] == CHANNEL));
                        state_d      = WAIT_D1;
                    end
                    4'hA, 4'hB, 4'hE: begin
                        skipLen_d = 2'd2;
                        skipCnt_d = 2'd2;
                        state_d   = SKIP;
                    end
                    4'hC, 4'hD: begin
                        skipLen_d = 2'd1;
                        skipCnt_d = 2'd1;
                        state_d   = SKIP;
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        note_d  = byte_data_i[6:0];
                        state_d = WAIT_D2;
                    end
                    WAIT_D2: begin
                        complete = !runDiscard_q;
                        state_d  = WAIT_D1;
                    end
                    SKIP: skipCnt_d = (skipCnt_q == 2'd1) ? skipLen_q : skipCnt_q - 2'd1;
                    default: ;
                endcase
            end
        end

        // A full slot that is not being drained this cycle drops the new event.
        if (complete && evtValid_q && !evt_ready_i) begin
            overrun_d = 1'b1;
        end else if (complete) begin
            evtValid_d = 1'b1;
            evtOn_d    = isOn;
            evtChan_d  = runChan_q;
            evtNote_d  = note_q;
            evtVel_d   = isOn ? byte_data_i[6:0] : 7'd0;
            if (isOn) begin
                led_d = {1'b1, note_q};
            end else if (led_q[6:0] == note_q) begin
                led_d = 8'h00;
            end
        end else if (evtValid_q && evt_ready_i) begin
            evtValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            runOn_q      <= 1'b0;
            runChan_q    <= 4'd0;
            runDiscard_q <= 1'b0;
            skipLen_q    <= 2'd0;
            skipCnt_q    <= 2'd0;
            note_q       <= 7'd0;
            evtValid_q   <= 1'b0;
            evtOn_q      <= 1'b0;
            evtChan_q    <= 4'd0;
            evtNote_q    <= 7'd0;
            evtVel_q     <= 7'd0;
            overrun_q    <= 1'b0;
            led_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            runOn_q      <= runOn_d;
            runChan_q    <= runChan_d;
            runDiscard_q <= runDiscard_d;
            skipLen_q    <= skipLen_d;
            skipCnt_q    <= skipCnt_d;
            note_q       <= note_d;
            evtValid_q   <= evtValid_d;
            evtOn_q      <= evtOn_d;
            evtChan_q    <= evtChan_d;
            evtNote_q    <= evtNote_d;
            evtVel_q     <= evtVel_d;
            overrun_q    <= overrun_d;
            led_q        <= led_d;
        end
    end

    assign evt_valid_o = evtValid_q;
    assign evt_on_o    = evtOn_q;
    assign evt_chan_o  = evtChan_q;
    assign evt_note_o  = evtNote_q;
    assign evt_vel_o   = evtVel_q;
    assign overrun_o   = overrun_q;
    assign led_o       = led_q;

endmodule
